// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared constants for the SPI flash arbiter.
//   - FSM state encodings (IDLE/LOAD/SHIFT/RESP/HOLD)
//   - owner encodings (port 0 = boot loader, port 1 = CPU register interface)
package spi_arb_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam logic OWNER_BOOT = 1'b0;
  localparam logic OWNER_CPU  = 1'b1;
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: one SPI mode-0 byte transfer (MSB first).
// Ports:
//   clock, reset  system clock, async active-high reset
//   start         pulse: latch tx and begin a byte
//   tx            byte to transmit
//   so            MISO, sampled on the clock edge that raises sck
//   sck, si       SPI clock (idle low) and MOSI
//   rx            received byte, valid once done fires
//   done          combinational: high on the edge that drops sck for the 8th time
module spi_byte_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       so,
  output logic       sck,
  output logic       si,
  output logic [7:0] rx,
  output logic       done
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic          active;
  logic          tick;

  assign tick = active && (div_cnt == DW'(CLK_DIV - 1));
  // Byte is finished on the falling sck edge of bit 7.
  assign done = tick && sck && (bit_cnt == 3'd7);
  assign si   = active & tx_sr[7];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx      <= '0;
      active  <= 1'b0;
      sck     <= 1'b0;
    end else if (start) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= tx;
      active  <= 1'b1;
      sck     <= 1'b0;
    end else if (active) begin
      if (tick) begin
        div_cnt <= '0;
        sck     <= ~sck;
        if (!sck) begin
          rx <= {rx[6:0], so};
        end else begin
          // si moves to the next bit only after the slave has sampled it
          tx_sr   <= {tx_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares one SPI flash between the boot loader (port 0)
// and the CPU SPI register interface (port 1). Owns CS framing, byte shifting
// and the inter-owner CS gap. Fixed priority (port 0 wins), no preemption:
// once granted, a port keeps CS low until it sends a byte flagged last.
// Ports:
//   clock, reset                 system clock, async active-high reset
//   reqN_valid/data/last/ready   per-port TX byte stream (valid/ready handshake)
//   rspN_valid/data              per-port RX byte, one-cycle valid pulse
//   flash_sck/si/cs_n/so         flash pins, SPI mode 0
//   owner                        current/last granted port
//   busy                         high whenever the FSM is not idle
//   timeout_err                  one-cycle pulse on a forced frame abort
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a frame whose owner
// leaves the bus idle for TIMEOUT_CYCLES while in LOAD; otherwise LOAD waits
// forever and timeout_err is tied low.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV        = 1,
  parameter int CS_HOLD        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic       flash_sck,
  output logic       flash_si,
  output logic       flash_cs_n,
  input  logic       flash_so,
  output logic       owner,
  output logic       busy,
  output logic       timeout_err
);
  localparam int HW = $clog2(CS_HOLD + 1);

  logic [2:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          last_q;
  logic          own_valid, own_last, hs, shift_done;
  logic [7:0]    own_data, rx;

  assign own_valid  = (owner == OWNER_CPU) ? req1_valid : req0_valid;
  assign own_data   = (owner == OWNER_CPU) ? req1_data  : req0_data;
  assign own_last   = (owner == OWNER_CPU) ? req1_last  : req0_last;
  assign req0_ready = (state == ST_LOAD) && (owner == OWNER_BOOT);
  assign req1_ready = (state == ST_LOAD) && (owner == OWNER_CPU);
  assign hs         = (state == ST_LOAD) && own_valid;
  assign busy       = (state != ST_IDLE);

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clock (clock),
    .reset (reset),
    .start (hs),
    .tx    (own_data),
    .so    (flash_so),
    .sck   (flash_sck),
    .si    (flash_si),
    .rx    (rx),
    .done  (shift_done)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      flash_cs_n <= 1'b1;
      owner      <= OWNER_BOOT;
      last_q     <= 1'b0;
      hold_cnt   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            owner      <= req0_valid ? OWNER_BOOT : OWNER_CPU;
            state      <= ST_LOAD;
            flash_cs_n <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            last_q <= own_last;
            state  <= ST_SHIFT;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt <= '0;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // owner went quiet mid-frame: release the flash
            to_cnt      <= '0;
            state       <= ST_HOLD;
            flash_cs_n  <= 1'b1;
            hold_cnt    <= '0;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            state <= ST_RESP;
            if (owner == OWNER_CPU) begin
              rsp1_valid <= 1'b1;
              rsp1_data  <= rx;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_data  <= rx;
            end
          end
        end
        ST_RESP: begin
          // non-last byte keeps CS low so the other port cannot cut in
          if (last_q) begin
            state      <= ST_HOLD;
            flash_cs_n <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            state <= ST_LOAD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HW'(CS_HOLD - 1)) state <= ST_IDLE;
          else hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;
  localparam int CS_HOLD = 4;
  localparam int CLK_DIV = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       r0v = 0, r0l = 0, r1v = 0, r1l = 0;
  logic [7:0] r0d = 0, r1d = 0;
  logic       r0r, r1r, s0v, s1v, sck, si, cs_n, own, busy, terr;
  logic [7:0] s0d, s1d;
  logic [7:0] so_sr = 8'h00;
  logic       so;
  assign so = so_sr[7];

  spi_flash_arbiter #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(r0v), .req0_data(r0d), .req0_last(r0l), .req0_ready(r0r),
    .rsp0_valid(s0v), .rsp0_data(s0d),
    .req1_valid(r1v), .req1_data(r1d), .req1_last(r1l), .req1_ready(r1r),
    .rsp1_valid(s1v), .rsp1_data(s1d),
    .flash_sck(sck), .flash_si(si), .flash_cs_n(cs_n), .flash_so(so),
    .owner(own), .busy(busy), .timeout_err(terr));

  // second instance for the divided-clock case
  logic       b_r0v = 0;
  logic [7:0] b_r0d = 8'hF0;
  logic       b_r0r, b_s0v, b_s1v, b_r1r, b_sck, b_si, b_cs_n, b_own, b_busy, b_terr;
  logic [7:0] b_s0d, b_s1d;
  spi_flash_arbiter #(.CLK_DIV(3), .CS_HOLD(CS_HOLD)) dut3 (
    .clock(clock), .reset(reset),
    .req0_valid(b_r0v), .req0_data(b_r0d), .req0_last(1'b1), .req0_ready(b_r0r),
    .rsp0_valid(b_s0v), .rsp0_data(b_s0d),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_last(1'b0), .req1_ready(b_r1r),
    .rsp1_valid(b_s1v), .rsp1_data(b_s1d),
    .flash_sck(b_sck), .flash_si(b_si), .flash_cs_n(b_cs_n), .flash_so(1'b0),
    .owner(b_own), .busy(b_busy), .timeout_err(b_terr));

  // flash model: presents so_sr MSB first, advancing on each falling sck
  always @(negedge sck) so_sr = {so_sr[6:0], so_sr[7]};
  logic [7:0] si_cap = 8'h00;
  int rises = 0;
  always @(posedge sck) begin
    si_cap = {si_cap[6:0], si};
    rises++;
  end

  int  p0 = 0, p1 = 0, to_pulses = 0;
  logic cs_mon = 0, cs_hi_seen = 0;
  always @(negedge clock) begin
    if (s0v) p0++;
    if (s1v) p1++;
    if (terr) to_pulses++;
    if (cs_mon && cs_n) cs_hi_seen = 1'b1;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int port, input logic [7:0] d, input logic l);
    logic got;
    got = 1'b0;
    if (port == 0) begin r0d = d; r0l = l; r0v = 1'b1; end
    else begin r1d = d; r1l = l; r1v = 1'b1; end
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if ((port == 0) ? r0r : r1r) begin got = 1'b1; break; end
    end
    chk("handshake", {31'd0, got}, 32'd1);
    @(posedge clock); #1;
    if (port == 0) r0v = 1'b0; else r1v = 1'b0;
  endtask

  task automatic wait_rsp(input int port, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if ((port == 0) ? s0v : s1v) begin got = 1'b1; break; end
    end
    chk(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!busy) begin got = 1'b1; break; end
    end
    chk("idle", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int k, hi, first_sck, base, h, l;
    logic got;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_si", {31'd0, si}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, own}, 32'd0);
    chk("rst_ready", {30'd0, r1r, r0r}, 32'd0);
    chk("rst_rsp", {14'd0, s1v, s0v, s1d, s0d}, 32'd0);
    chk("rst_terr", {31'd0, terr}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // single byte on port 0: SI = 10101011, flash returns 0x5A
    so_sr = 8'h5A;
    send(0, 8'hAB, 1'b1);
    wait_rsp(0, "t1_rsp");
    chk("t1_si_bits", {24'd0, si_cap}, 32'hAB);
    chk("t1_rx", {24'd0, s0d}, 32'h5A);
    @(negedge clock);
    chk("t1_pulse_1cyc", {31'd0, s0v}, 32'd0);
    wait_idle();

    // simultaneous requests: port 0 wins, port 1 waits out frame + HOLD
    so_sr = 8'hC3;
    r0d = 8'h9F; r0l = 1'b1; r1d = 8'h03; r1l = 1'b0;
    r0v = 1'b1; r1v = 1'b1;
    @(negedge clock);
    chk("t2_owner0", {31'd0, own}, 32'd0);
    chk("t2_ready", {30'd0, r1r, r0r}, 32'd1);
    @(posedge clock); #1 r0v = 1'b0;
    wait_rsp(0, "t2_rsp0");
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock); k++;
      if (r1r) break;
    end
    // HOLD cycles, one IDLE cycle, then LOAD for port 1
    chk("t2_r1_wait", k, CS_HOLD + 2);
    chk("t2_owner1", {31'd0, own}, 32'd1);

    // 5-byte frame on port 1: CS stays low, 5 response pulses
    base = p1;
    cs_mon = 1'b1;
    @(posedge clock); #1 r1v = 1'b0;
    wait_rsp(1, "t3_rsp_a");
    send(1, 8'h08, 1'b0); wait_rsp(1, "t3_rsp_b");
    send(1, 8'h00, 1'b0); wait_rsp(1, "t3_rsp_c");
    send(1, 8'h00, 1'b0); wait_rsp(1, "t3_rsp_d");
    r0d = 8'h00; r0l = 1'b1; r0v = 1'b1;   // port 0 queued behind the frame
    send(1, 8'h00, 1'b1); wait_rsp(1, "t3_rsp_e");
    cs_mon = 1'b0;
    #1;
    chk("t3_pulses", p1 - base, 5);
    chk("t3_cs_low", {31'd0, cs_hi_seen}, 32'd0);
    chk("t3_rx", {24'd0, s1d}, 32'hC3);

    // frame-to-frame gap, measured from the RESP-cycle sample
    hi = 0; first_sck = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (cs_n) hi++;
      if (sck) begin first_sck = i; break; end
    end
    chk("t4_cs_high", hi, CS_HOLD + 1);
    chk("t4_first_sck", first_sck, CS_HOLD + 3 + CLK_DIV);
    r0v = 1'b0;
    wait_rsp(0, "t4_rsp0");
    chk("t4_rx", {24'd0, s0d}, 32'hC3);
    wait_idle();

    // reset during 4th bit of SHIFT
    base = rises;
    send(0, 8'h55, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if ((rises - base) == 4 && sck) begin got = 1'b1; break; end
    end
    chk("t5_reach_bit4", {31'd0, got}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t5_cs_n", {31'd0, cs_n}, 32'd1);
    chk("t5_sck", {31'd0, sck}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    base = p0;
    repeat (40) @(negedge clock);
    #1;
    chk("t5_no_rsp", p0 - base, 0);
    chk("t5_cs_idle", {31'd0, cs_n}, 32'd1);

    // owner stalls mid-frame
    send(1, 8'h11, 1'b0);
    wait_rsp(1, "t6_rsp");
`ifdef SPI_ARB_TIMEOUT_EN
    base = to_pulses;
    repeat (16) @(negedge clock);
    chk("t6_cs_before", {31'd0, cs_n}, 32'd0);
    @(negedge clock);
    chk("t6_cs_abort", {31'd0, cs_n}, 32'd1);
    chk("t6_terr", {31'd0, terr}, 32'd1);
    @(negedge clock);
    chk("t6_terr_1cyc", {31'd0, terr}, 32'd0);
    wait_idle();
    #1;
    chk("t6_terr_count", to_pulses - base, 1);
`else
    repeat (40) @(negedge clock);
    chk("t6_cs_held", {31'd0, cs_n}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_terr0", {31'd0, terr}, 32'd0);
    send(1, 8'h22, 1'b1);
    wait_rsp(1, "t6_rsp_last");
    wait_idle();
    chk("t6_cs_rel", {31'd0, cs_n}, 32'd1);
`endif

    // CLK_DIV=3: sck high 3 cycles, low 3 cycles
    b_r0v = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (b_r0r) begin got = 1'b1; break; end
    end
    chk("t7_hs", {31'd0, got}, 32'd1);
    @(posedge clock); #1 b_r0v = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (b_sck) begin got = 1'b1; break; end
    end
    chk("t7_sck_rise", {31'd0, got}, 32'd1);
    h = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!b_sck) break;
      h++;
    end
    l = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (b_sck) break;
      l++;
    end
    chk("t7_sck_high", h, 3);
    chk("t7_sck_low", l, 3);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (b_s0v) begin got = 1'b1; break; end
    end
    chk("t7_rsp", {31'd0, got}, 32'd1);
    chk("t7_rx", {24'd0, b_s0d}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
